jt10_adpcma_regseq: RTL and testbench

- Register front-end and sequencer for the 6-channel ADPCM-A address counter pipeline.
- Decodes CPU writes to ADPCM-A registers (key, flag clear, start/end address LSB/MSB) and holds them until the matching channel slot of the rotating one-hot cur_ch.
- Issues single-channel aon/aoff pulses and addr_in/addr_ch/up_start/up_end to the counter, and clr_flags to its flag register.
- Sits between the YM2610 bus decoder and the ADPCM-A counter; runs on the CPU clock with the 666 kHz cen.

---
 rtl/jt10_adpcma_regseq.sv | 132 +++++++++++++
 tb/tb_jt10_adpcma_regseq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcma_regseq.sv
// ADPCM-A register front-end: decodes CPU writes, holds key requests and
// queued address updates until the matching cur_ch slot of the counter.
module jt10_adpcma_regseq #(
   parameter int unsigned FIFO_AW = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic [5:0]  cur_ch,
   input  logic        wr,
   input  logic [7:0]  waddr,
   input  logic [7:0]  din,
   output logic        aon,
   output logic        aoff,
   output logic [15:0] addr_in,
   output logic [2:0]  addr_ch,
   output logic        up_start,
   output logic        up_end,
   output logic [5:0]  clr_flags,
   output logic        busy,
   output logic        ovf
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;

   logic [5:0]         r_pend_on, r_pend_off, r_clr;
   logic [7:0]         r_start_lsb [6];
   logic [7:0]         r_end_lsb   [6];
   logic               r_q_end [DEPTH];
   logic [2:0]         r_q_ch  [DEPTH];
   logic [15:0]        r_q_val [DEPTH];
   logic [FIFO_AW-1:0] r_rd, r_wr;
   logic [FIFO_AW:0]   r_cnt;
   logic               r_ovf;

   logic [2:0]  w_ch;
   logic        w_is_addr, w_wr_key, w_wr_flag, w_wr_lsb, w_wr_msb;
   logic        w_empty, w_full, w_head_slot, w_pop, w_push, w_drop;
   logic [5:0]  w_head_oh, w_fifo_mask, w_on_nxt, w_off_nxt;
   logic [7:0]  w_lsb;

   assign w_ch      = waddr[2:0];
   assign w_is_addr = ((waddr[7:4] == 4'h1) || (waddr[7:4] == 4'h2)) && (w_ch < 3'd6);
   assign w_wr_key  = wr && (waddr == 8'h00);
   assign w_wr_flag = wr && (waddr == 8'h07);
   assign w_wr_lsb  = wr && w_is_addr && !waddr[3];
   assign w_wr_msb  = wr && w_is_addr && waddr[3];
   assign w_lsb     = waddr[5] ? r_end_lsb[w_ch] : r_start_lsb[w_ch];

   assign w_empty     = (r_cnt == '0);
   assign w_full      = (r_cnt == (FIFO_AW+1)'(DEPTH));
   assign w_head_oh   = 6'd1 << r_q_ch[r_rd];
   assign w_head_slot = !w_empty && (cur_ch == w_head_oh);
   assign w_pop       = cen && w_head_slot;
   // A pop in the same clk frees the slot, so a push into a full FIFO survives.
   assign w_push      = w_wr_msb && (!w_full || w_pop);
   assign w_drop      = w_wr_msb && w_full && !w_pop;

   always_comb begin
      w_fifo_mask = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((FIFO_AW+1)'(i) < r_cnt)
            w_fifo_mask = w_fifo_mask | (6'd1 << r_q_ch[r_rd + FIFO_AW'(i)]);
      end
   end

   // Slot clears are applied first so a same-clk key write wins.
   always_comb begin
      w_on_nxt  = r_pend_on;
      w_off_nxt = r_pend_off;
      if (cen) begin
         w_on_nxt  = w_on_nxt & ~(cur_ch & ~w_fifo_mask);
         w_off_nxt = w_off_nxt & ~cur_ch;
      end
      if (w_wr_key) begin
         if (din[7]) begin
            w_off_nxt = w_off_nxt | din[5:0];
            w_on_nxt  = w_on_nxt & ~din[5:0];
         end else begin
            w_on_nxt  = w_on_nxt | din[5:0];
            w_off_nxt = w_off_nxt & ~din[5:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_on  <= '0;
         r_pend_off <= '0;
         r_clr      <= '0;
         r_rd       <= '0;
         r_wr       <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         for (int unsigned i = 0; i < 6; i++) begin
            r_start_lsb[i] <= '0;
            r_end_lsb[i]   <= '0;
         end
      end else begin
         r_pend_on  <= w_on_nxt;
         r_pend_off <= w_off_nxt;
         r_clr      <= w_wr_flag ? din[5:0] : '0;
         if (w_wr_lsb) begin
            if (waddr[5]) r_end_lsb[w_ch]   <= din;
            else          r_start_lsb[w_ch] <= din;
         end
         if (w_push) r_wr <= r_wr + FIFO_AW'(1);
         if (w_pop)  r_rd <= r_rd + FIFO_AW'(1);
         r_cnt <= r_cnt + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_end[r_wr] <= waddr[5];
         r_q_ch[r_wr]  <= w_ch;
         r_q_val[r_wr] <= {din, w_lsb};
      end
   end

   assign aoff      = |(r_pend_off & cur_ch);
   assign aon       = |(r_pend_on & cur_ch & ~w_fifo_mask);
   assign addr_in   = w_empty ? '0 : r_q_val[r_rd];
   assign addr_ch   = w_empty ? '0 : r_q_ch[r_rd];
   assign up_start  = w_head_slot && !r_q_end[r_rd];
   assign up_end    = w_head_slot && r_q_end[r_rd];
   assign clr_flags = r_clr;
   assign ovf       = r_ovf;
   assign busy      = (|r_pend_on) || (|r_pend_off) || !w_empty;

endmodule

// File: tb/tb_jt10_adpcma_regseq.sv
// Bench for jt10_adpcma_regseq: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_jt10_adpcma_regseq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen;
   logic [5:0]  cur_ch;
   logic        wr;
   logic [7:0]  waddr, din;
   logic        aon, aoff, up_start, up_end, busy, ovf;
   logic [15:0] addr_in;
   logic [2:0]  addr_ch;
   logic [5:0]  clr_flags;

   jt10_adpcma_regseq #(.FIFO_AW(2)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .cur_ch(cur_ch), .wr(wr),
      .waddr(waddr), .din(din), .aon(aon), .aoff(aoff), .addr_in(addr_in),
      .addr_ch(addr_ch), .up_start(up_start), .up_end(up_end),
      .clr_flags(clr_flags), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        aon, aoff, up_start, up_end;
      logic [15:0] addr_in;
      logic [2:0]  addr_ch;
      logic [5:0]  clr;
      logic        busy, ovf;
   } outs_t;

   typedef struct {
      logic       wr;
      logic [7:0] a, d;
      logic       cen;
      logic [5:0] ch;
      outs_t      exp;
   } vec_t;

   typedef struct {
      bit          is_end;
      int          ch;
      logic [15:0] val;
   } ent_t;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   ent_t       q[$];
   bit         m_on[6], m_off[6];
   logic [7:0] m_slsb[6], m_elsb[6];
   logic [5:0] m_clr;
   bit         m_ovf;

   function automatic outs_t o(bit a_on, bit a_off, bit us, bit ue, logic [15:0] ai,
                               logic [2:0] ac, logic [5:0] cl, bit b, bit ov);
      outs_t r;
      r.aon = a_on; r.aoff = a_off; r.up_start = us; r.up_end = ue;
      r.addr_in = ai; r.addr_ch = ac; r.clr = cl; r.busy = b; r.ovf = ov;
      return r;
   endfunction

   function automatic int ch_idx(logic [5:0] v);
      for (int i = 0; i < 6; i++) if (v == (6'd1 << i)) return i;
      return -1;
   endfunction

   function automatic outs_t dut_out();
      return o(aon, aoff, up_start, up_end, addr_in, addr_ch, clr_flags, busy, ovf);
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 6; i++) begin
         m_on[i] = 0; m_off[i] = 0; m_slsb[i] = '0; m_elsb[i] = '0;
      end
      m_clr = '0;
      m_ovf = 0;
   endtask

   function automatic outs_t model_out();
      outs_t r;
      int c;
      bit inq[6];
      bit any;
      r = '0;
      c = ch_idx(cur_ch);
      any = 0;
      for (int i = 0; i < 6; i++) inq[i] = 0;
      foreach (q[k]) inq[q[k].ch] = 1;
      for (int i = 0; i < 6; i++) if (m_on[i] || m_off[i]) any = 1;
      if (c >= 0) begin
         r.aon  = m_on[c] && !inq[c];
         r.aoff = m_off[c];
      end
      if (q.size() > 0) begin
         r.addr_in  = q[0].val;
         r.addr_ch  = 3'(q[0].ch);
         r.up_start = (c == q[0].ch) && !q[0].is_end;
         r.up_end   = (c == q[0].ch) && q[0].is_end;
      end
      r.clr  = m_clr;
      r.busy = any || (q.size() > 0);
      r.ovf  = m_ovf;
      return r;
   endfunction

   task automatic model_step();
      int c;
      bit inq[6];
      ent_t e;
      logic [3:0] hi, lo;
      c = ch_idx(cur_ch);
      for (int i = 0; i < 6; i++) inq[i] = 0;
      foreach (q[k]) inq[q[k].ch] = 1;
      if (cen && c >= 0) begin
         if (!inq[c]) m_on[c] = 0;
         m_off[c] = 0;
      end
      if (cen && q.size() > 0 && c == q[0].ch) void'(q.pop_front());
      m_clr = '0;
      if (wr) begin
         hi = waddr[7:4];
         lo = waddr[3:0];
         if (waddr == 8'h00) begin
            for (int i = 0; i < 6; i++) if (din[i]) begin
               m_on[i]  = !din[7];
               m_off[i] = din[7];
            end
         end else if (waddr == 8'h07) begin
            m_clr = din[5:0];
         end else if ((hi == 4'h1 || hi == 4'h2) && lo[2:0] < 3'd6) begin
            if (!lo[3]) begin
               if (hi == 4'h2) m_elsb[lo[2:0]] = din;
               else            m_slsb[lo[2:0]] = din;
            end else begin
               e.is_end = (hi == 4'h2);
               e.ch     = int'(lo[2:0]);
               e.val    = {din, e.is_end ? m_elsb[lo[2:0]] : m_slsb[lo[2:0]]};
               if (q.size() < 4) q.push_back(e);
               else              m_ovf = 1;
            end
         end
      end
   endtask

   task automatic chk(string name, outs_t exp);
      outs_t got;
      got = dut_out();
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h required %h (aon,aoff,us,ue,addr,ch,clr,busy,ovf)",
                  name, $time, got, exp);
      end
   endtask

   task automatic drive(logic w, logic [7:0] a, logic [7:0] d, logic c, logic [5:0] ch);
      wr = w; waddr = a; din = d; cen = c; cur_ch = ch;
   endtask

   // called at posedge+1: sample at negedge, then advance one clk
   task automatic cyc_chk(string name, outs_t exp);
      @(negedge clk);
      chk(name, exp);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      drive(0, 8'h00, 8'h00, 0, 6'b000001);
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
   endtask

   vec_t tbl[20];
   int   ridx;

   initial begin
      tbl[0]  = '{1, 8'h07, 8'h2A, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[1]  = '{0, 8'h00, 8'h00, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h2A,0,0)};
      tbl[2]  = '{0, 8'h00, 8'h00, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[3]  = '{1, 8'h12, 8'h34, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[4]  = '{1, 8'h1A, 8'h01, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[5]  = '{1, 8'h00, 8'h04, 0, 6'b000001, o(0,0,0,0,16'h0134,2,6'h00,1,0)};
      tbl[6]  = '{0, 8'h00, 8'h00, 0, 6'b000100, o(0,0,1,0,16'h0134,2,6'h00,1,0)};
      tbl[7]  = '{0, 8'h00, 8'h00, 1, 6'b000100, o(0,0,1,0,16'h0134,2,6'h00,1,0)};
      tbl[8]  = '{0, 8'h00, 8'h00, 0, 6'b000100, o(1,0,0,0,16'h0000,0,6'h00,1,0)};
      tbl[9]  = '{0, 8'h00, 8'h00, 1, 6'b000100, o(1,0,0,0,16'h0000,0,6'h00,1,0)};
      tbl[10] = '{0, 8'h00, 8'h00, 0, 6'b000100, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[11] = '{1, 8'h00, 8'h01, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[12] = '{1, 8'h00, 8'h81, 0, 6'b000010, o(0,0,0,0,16'h0000,0,6'h00,1,0)};
      tbl[13] = '{0, 8'h00, 8'h00, 0, 6'b000001, o(0,1,0,0,16'h0000,0,6'h00,1,0)};
      tbl[14] = '{0, 8'h00, 8'h00, 1, 6'b000001, o(0,1,0,0,16'h0000,0,6'h00,1,0)};
      tbl[15] = '{0, 8'h00, 8'h00, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[16] = '{1, 8'h1E, 8'h55, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[17] = '{1, 8'h16, 8'h12, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[18] = '{1, 8'h2F, 8'h12, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};
      tbl[19] = '{0, 8'h00, 8'h00, 0, 6'b000001, o(0,0,0,0,16'h0000,0,6'h00,0,0)};

      rst_n = 1;
      drive(0, 8'h00, 8'h00, 0, 6'b000001);
      @(posedge clk); #1;
      do_reset();
      chk("reset_state", o(0,0,0,0,16'h0000,0,6'h00,0,0));

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].cen, tbl[i].ch);
         cyc_chk($sformatf("vec%0d", i), tbl[i].exp);
      end

      // key-on 0x05 across one rotation
      do_reset();
      drive(1, 8'h00, 8'h05, 0, 6'b100000);
      cyc_chk("keyon_wr", o(0,0,0,0,16'h0000,0,6'h00,0,0));
      for (int k = 0; k < 6; k++) begin
         drive(0, 8'h00, 8'h00, 1, 6'd1 << k);
         cyc_chk($sformatf("keyon_slot%0d", k),
                 o((k == 0 || k == 2), 0, 0, 0, 16'h0000, 0, 6'h00, (k <= 2), 0));
      end
      drive(0, 8'h00, 8'h00, 0, 6'b000001);
      cyc_chk("keyon_idle", o(0,0,0,0,16'h0000,0,6'h00,0,0));

      // overflow: five end-MSB writes with cen held low
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1, 8'h28 + 8'(k), 8'h10 + 8'(k), 0, 6'b000001);
         @(posedge clk); model_step(); #1;
      end
      drive(0, 8'h00, 8'h00, 0, 6'b000001);
      cyc_chk("ovf_full", o(0,0,0,1,16'h1000,0,6'h00,1,1));
      for (int k = 0; k < 4; k++) begin
         drive(0, 8'h00, 8'h00, 1, 6'd1 << k);
         cyc_chk($sformatf("ovf_pop%0d", k),
                 o(0, 0, 0, 1, {8'h10 + 8'(k), 8'h00}, 3'(k), 6'h00, 1, 1));
      end
      drive(0, 8'h00, 8'h00, 0, 6'b010000);
      cyc_chk("ovf_drained", o(0,0,0,0,16'h0000,0,6'h00,0,1));

      // asynchronous reset in the middle of activity
      drive(1, 8'h18, 8'hAA, 0, 6'b000001); @(posedge clk); #1;
      drive(1, 8'h19, 8'hBB, 0, 6'b000001); @(posedge clk); #1;
      drive(1, 8'h1A, 8'hCC, 0, 6'b000001); @(posedge clk); #1;
      drive(1, 8'h00, 8'h3F, 0, 6'b000001); @(posedge clk); #1;
      drive(0, 8'h00, 8'h00, 0, 6'b000001);
      #1 rst_n = 0;
      #1 chk("async_reset", o(0,0,0,0,16'h0000,0,6'h00,0,0));
      @(posedge clk); #1 rst_n = 1;
      model_reset();
      for (int k = 0; k < 12; k++) begin
         drive(0, 8'h00, 8'h00, 1, 6'd1 << (k % 6));
         cyc_chk($sformatf("post_reset%0d", k), o(0,0,0,0,16'h0000,0,6'h00,0,0));
      end

      // randomized run against the reference model
      do_reset();
      ridx = 0;
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] a;
         logic       c;
         case ($urandom % 6)
            0: a = 8'h00;
            1: a = 8'h07;
            2: a = 8'h10 + 8'($urandom % 16);
            3: a = 8'h20 + 8'($urandom % 16);
            4: a = 8'($urandom);
            default: a = 8'h18 + 8'($urandom % 6) + (($urandom % 2) != 0 ? 8'h10 : 8'h00);
         endcase
         c = (($urandom % 3) == 0);
         drive(($urandom % 2) != 0, a, 8'($urandom), c, 6'd1 << ridx);
         cyc_chk("random", model_out());
         if (c) ridx = (ridx + 1) % 6;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
